// File: rtl/kvs_resp_tx.sv
// Memcache binary-protocol response transmitter: streams one Ethernet/IPv4/UDP
// response frame per accepted descriptor onto GMII, value bytes fetched from RAM.
module kvs_resp_tx #(
  parameter logic [47:0] SRC_MAC     = 48'h00301ba0a48e,
  parameter logic [31:0] SRC_IP      = 32'h0a00150a,
  parameter logic [15:0] LISTEN_PORT = 16'd11211,
  parameter logic [10:0] VAL_MAX     = 11'd1024,
  parameter int unsigned IFG         = 12
) (
  input  logic        gtx_clk,
  input  logic        sys_rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_opcode,
  input  logic [15:0] req_status,
  input  logic [31:0] req_opaque,
  input  logic [31:0] req_flags,
  input  logic [10:0] req_val_len,
  input  logic [16:0] req_val_base,
  input  logic [47:0] req_dst_mac,
  input  logic [31:0] req_dst_ip,
  input  logic [15:0] req_dst_port,
  output logic [16:0] mem_address,
  input  logic [7:0]  mem_q,
  output logic        tx_en,
  output logic [7:0]  txd,
  output logic        tx_done
);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_HDR, S_EXT, S_VAL, S_FCS, S_GAP} state_e;

  localparam logic [10:0] GAP_LAST = 11'(IFG - 1);

  state_e        state_q, state_d;
  logic [10:0]   cnt_q, cnt_d;
  logic          ready_q, tx_en_q, tx_done_q;
  logic [7:0]    txd_q, byte_d;
  logic [16:0]   addr_q;
  logic [31:0]   crc_q;
  logic [15:0]   csum_q;
  logic [7:0]    op_q;
  logic [15:0]   status_q, port_q;
  logic [31:0]   opaque_q, flags_q, ip_q;
  logic [10:0]   n_q;
  logic [16:0]   base_q;
  logic [47:0]   mac_q;
  logic          hit_q;

  logic          accept_s;
  logic [7:0]    txd_s;
  logic [15:0]   body_s, ip_total_s, udp_len_s;
  logic [527:0]  hdr_s;
  logic [9:0]    hdr_idx_s;
  logic [31:0]   crc_next_s, fcs_inv_s;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hedb88320) : (c >> 1);
    end
    return c;
  endfunction

  function automatic logic [15:0] ip_csum(input logic [15:0] total, input logic [31:0] dst);
    logic [19:0] s;
    s = 20'h04500 + {4'h0, total} + 20'h04000 + 20'h04011
      + {4'h0, SRC_IP[31:16]} + {4'h0, SRC_IP[15:0]}
      + {4'h0, dst[31:16]} + {4'h0, dst[15:0]};
    s = {4'h0, s[15:0]} + {16'h0000, s[19:16]};
    s = {4'h0, s[15:0]} + {16'h0000, s[19:16]};
    return ~s[15:0];
  endfunction

  assign accept_s   = req_valid && ready_q && (state_q == S_IDLE);
  assign txd_s      = (state_q == S_VAL) ? mem_q : txd_q;
  assign body_s     = hit_q ? (16'd4 + {5'd0, n_q}) : 16'd0;
  assign ip_total_s = 16'd52 + body_s;
  assign udp_len_s  = 16'd32 + body_s;
  assign crc_next_s = crc32_byte(crc_q, txd_s);
  // The first FCS byte must already include the last payload byte.
  assign fcs_inv_s  = ~((state_q == S_FCS) ? crc_q : crc_next_s);
  assign hdr_s = {mac_q, SRC_MAC, 16'h0800,
                  16'h4500, ip_total_s, 16'h0000, 16'h4000, 8'h40, 8'h11, csum_q, SRC_IP, ip_q,
                  LISTEN_PORT, port_q, udp_len_s, 16'h0000,
                  8'h81, op_q, 16'h0000, (hit_q ? 8'h04 : 8'h00), 8'h00, status_q,
                  {16'h0000, body_s}, opaque_q, 64'h0};
  assign hdr_idx_s = 10'd520 - {cnt_d[6:0], 3'b000};

  // Next frame position: state_q/cnt_q describe the byte currently on txd.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (accept_s) begin state_d = S_PRE; cnt_d = 11'd0; end
              else begin state_d = S_IDLE; cnt_d = 11'd0; end
      S_PRE:  if (cnt_q == 11'd7) begin state_d = S_HDR; cnt_d = 11'd0; end
              else begin cnt_d = cnt_q + 11'd1; end
      S_HDR:  if (cnt_q == 11'd65) begin state_d = hit_q ? S_EXT : S_FCS; cnt_d = 11'd0; end
              else begin cnt_d = cnt_q + 11'd1; end
      S_EXT:  if (cnt_q == 11'd3) begin state_d = (n_q != 11'd0) ? S_VAL : S_FCS; cnt_d = 11'd0; end
              else begin cnt_d = cnt_q + 11'd1; end
      S_VAL:  if (cnt_q == n_q - 11'd1) begin state_d = S_FCS; cnt_d = 11'd0; end
              else begin cnt_d = cnt_q + 11'd1; end
      S_FCS:  if (cnt_q == 11'd3) begin state_d = S_GAP; cnt_d = 11'd0; end
              else begin cnt_d = cnt_q + 11'd1; end
      S_GAP:  if (cnt_q == GAP_LAST) begin state_d = S_IDLE; cnt_d = 11'd0; end
              else begin cnt_d = cnt_q + 11'd1; end
      default: begin state_d = S_IDLE; cnt_d = 11'd0; end
    endcase
  end

  // Byte to present on txd in the next cycle.
  always_comb begin
    byte_d = 8'h00;
    case (state_d)
      S_PRE: byte_d = (cnt_d == 11'd7) ? 8'hd5 : 8'h55;
      S_HDR: byte_d = hdr_s[hdr_idx_s +: 8];
      S_EXT: case (cnt_d[1:0])
               2'd0:    byte_d = flags_q[31:24];
               2'd1:    byte_d = flags_q[23:16];
               2'd2:    byte_d = flags_q[15:8];
               default: byte_d = flags_q[7:0];
             endcase
      S_FCS: case (cnt_d[1:0])
               2'd0:    byte_d = fcs_inv_s[7:0];
               2'd1:    byte_d = fcs_inv_s[15:8];
               2'd2:    byte_d = fcs_inv_s[23:16];
               default: byte_d = fcs_inv_s[31:24];
             endcase
      default: byte_d = 8'h00;
    endcase
  end

  // FSM state, handshake and GMII output registers.
  always_ff @(posedge gtx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 11'd0;
      ready_q   <= 1'b0;
      tx_en_q   <= 1'b0;
      txd_q     <= 8'h00;
      tx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ready_q   <= (state_d == S_IDLE);
      tx_en_q   <= (state_d inside {S_PRE, S_HDR, S_EXT, S_VAL, S_FCS});
      txd_q     <= byte_d;
      tx_done_q <= (state_q == S_FCS) && (cnt_q == 11'd3);
    end
  end

  // Descriptor capture on accept.
  always_ff @(posedge gtx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      op_q <= 8'h00; status_q <= 16'h0000; opaque_q <= 32'h0; flags_q <= 32'h0;
      n_q <= 11'd0; base_q <= 17'd0; mac_q <= 48'h0; ip_q <= 32'h0; port_q <= 16'h0000;
      hit_q <= 1'b0;
    end else if (accept_s) begin
      op_q     <= req_opcode;
      status_q <= req_status;
      opaque_q <= req_opaque;
      flags_q  <= req_flags;
      n_q      <= (req_val_len > VAL_MAX) ? VAL_MAX : req_val_len;
      base_q   <= req_val_base;
      mac_q    <= req_dst_mac;
      ip_q     <= req_dst_ip;
      port_q   <= req_dst_port;
      hit_q    <= (req_opcode == 8'h00) && (req_status == 16'h0000);
    end else begin
      hit_q    <= hit_q;
    end
  end

  // Running FCS, IP header checksum and value RAM read pointer.
  always_ff @(posedge gtx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      crc_q  <= 32'hffffffff;
      csum_q <= 16'h0000;
      addr_q <= 17'd0;
    end else begin
      if (accept_s) begin
        crc_q <= 32'hffffffff;
      end else if (state_q inside {S_HDR, S_EXT, S_VAL}) begin
        crc_q <= crc_next_s;
      end else begin
        crc_q <= crc_q;
      end
      if (state_q == S_PRE) begin
        csum_q <= ip_csum(ip_total_s, ip_q);
      end else begin
        csum_q <= csum_q;
      end
      // Address runs one cycle ahead so the RAM output meets the VAL byte slot.
      if ((state_d == S_EXT) && (cnt_d == 11'd3)) begin
        addr_q <= base_q;
      end else if (state_d == S_VAL) begin
        addr_q <= addr_q + 17'd1;
      end else begin
        addr_q <= addr_q;
      end
    end
  end

  assign req_ready   = ready_q;
  assign tx_en       = tx_en_q;
  assign txd         = txd_s;
  assign tx_done     = tx_done_q;
  assign mem_address = addr_q;

endmodule
